spi_slave: RTL

- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) for the `spi_master` frame: DATA_WIDTH address bits, then DATA_WIDTH data bits, all inside one `ss`-low window.
- Runs on the system clock. `ss`, `sclk` and `mosi` are oversampled through synchronisers.
- Write frames are presented as a one-cycle `wr_valid` strobe. Read frames request data from a user register bank and shift it back on `miso`.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_slave.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI types and defaults used by spi_slave and spi_master.
package spi_pkg;

  localparam int unsigned SPI_DATA_WIDTH = 8;
  localparam int unsigned SPI_LEN_WIDTH  = 4;
  localparam int unsigned SPI_RD_BIT     = SPI_DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT_SS
  } spi_slave_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser with single-cycle rise/fall pulses on the synchronised level.
module spi_sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [Stages-1:0] r_sync;
  logic              r_prev;
  logic              w_level;

  assign w_level = r_sync[Stages-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[Stages-2:0], i_async};
      r_prev <= w_level;
    end
  end

  assign o_rise = w_level & ~r_prev;
  assign o_fall = ~w_level & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: address frame then write data or read-back on miso.
// Optional frame_err/err_cnt outputs are enabled by defining SPI_SLAVE_FRAME_ERR_EN.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH   = SPI_LEN_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss,
  output logic                  miso,
  output logic                  wr_valid,
  output logic [DATA_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic                  frame_err,
  output logic [7:0]            err_cnt
`endif
);

  localparam int unsigned RdBit = DATA_WIDTH - 1;

  logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall, w_mosi, w_last_bit;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  spi_slave_state_t      r_state, w_state_d;
  logic [LEN_WIDTH-1:0]  r_bit_cnt, w_bit_cnt_d;
  logic [DATA_WIDTH-1:0] r_addr_sr, w_addr_sr_d;
  logic [DATA_WIDTH-1:0] r_data_sr, w_data_sr_d;
  logic [DATA_WIDTH-1:0] r_tx_sr, w_tx_sr_d;
  logic [DATA_WIDTH-1:0] r_wr_addr, w_wr_addr_d;
  logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_d;
  logic [DATA_WIDTH-1:0] r_rd_addr, w_rd_addr_d;
  logic r_is_read, w_is_read_d;
  logic r_skip_fall, w_skip_fall_d;
  logic r_wr_valid, w_wr_valid_d;
  logic r_rd_req, w_rd_req_d;
  logic r_miso, w_miso_d;

  spi_sync_edge #(
    .Stages (SYNC_STAGES)
  ) u_sync_ss (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ss),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  spi_sync_edge #(
    .Stages (SYNC_STAGES)
  ) u_sync_sclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (sclk),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  // Same depth as the sclk path so mosi is sampled in step with the detected rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_last_bit = (r_bit_cnt == LEN_WIDTH'(DATA_WIDTH - 1));

  always_comb begin
    w_state_d     = r_state;
    w_bit_cnt_d   = r_bit_cnt;
    w_addr_sr_d   = r_addr_sr;
    w_data_sr_d   = r_data_sr;
    w_tx_sr_d     = r_rd_req ? rd_data : r_tx_sr;
    w_is_read_d   = r_is_read;
    w_skip_fall_d = r_skip_fall;
    w_wr_addr_d   = r_wr_addr;
    w_wr_data_d   = r_wr_data;
    w_rd_addr_d   = r_rd_addr;
    w_wr_valid_d  = 1'b0;
    w_rd_req_d    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_state_d   = ADDR;
          w_bit_cnt_d = '0;
        end
      end
      ADDR: begin
        if (w_ss_rise) begin
          w_state_d = IDLE;
        end else if (w_sclk_rise) begin
          w_addr_sr_d = {r_addr_sr[DATA_WIDTH-2:0], w_mosi};
          if (w_last_bit) begin
            w_state_d     = DATA;
            w_bit_cnt_d   = '0;
            w_is_read_d   = w_addr_sr_d[RdBit];
            w_skip_fall_d = 1'b1;
            w_tx_sr_d     = '0;
            if (w_addr_sr_d[RdBit]) begin
              w_rd_req_d  = 1'b1;
              w_rd_addr_d = {1'b0, w_addr_sr_d[DATA_WIDTH-2:0]};
            end
          end else begin
            w_bit_cnt_d = r_bit_cnt + LEN_WIDTH'(1);
          end
        end
      end
      DATA: begin
        if (w_sclk_rise) begin
          w_data_sr_d = {r_data_sr[DATA_WIDTH-2:0], w_mosi};
          if (w_last_bit) begin
            if (!r_is_read) begin
              w_wr_valid_d = 1'b1;
              w_wr_addr_d  = {1'b0, r_addr_sr[DATA_WIDTH-2:0]};
              w_wr_data_d  = w_data_sr_d;
            end
            // A deselect coinciding with the final rise still completes the frame.
            w_state_d = w_ss_rise ? IDLE : WAIT_SS;
          end else begin
            w_bit_cnt_d = r_bit_cnt + LEN_WIDTH'(1);
            if (w_ss_rise) w_state_d = IDLE;
          end
        end else if (w_ss_rise) begin
          w_state_d = IDLE;
        end else if (w_sclk_fall && r_is_read) begin
          // The fall right after the address keeps the MSB up for the first data rise.
          if (r_skip_fall) begin
            w_skip_fall_d = 1'b0;
          end else begin
            w_tx_sr_d = {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      WAIT_SS: begin
        if (w_ss_rise) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase

    w_miso_d = (w_state_d == DATA && w_is_read_d) ? w_tx_sr_d[RdBit] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_addr_sr   <= '0;
      r_data_sr   <= '0;
      r_tx_sr     <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_addr   <= '0;
      r_is_read   <= 1'b0;
      r_skip_fall <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_rd_req    <= 1'b0;
      r_miso      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_addr_sr   <= w_addr_sr_d;
      r_data_sr   <= w_data_sr_d;
      r_tx_sr     <= w_tx_sr_d;
      r_wr_addr   <= w_wr_addr_d;
      r_wr_data   <= w_wr_data_d;
      r_rd_addr   <= w_rd_addr_d;
      r_is_read   <= w_is_read_d;
      r_skip_fall <= w_skip_fall_d;
      r_wr_valid  <= w_wr_valid_d;
      r_rd_req    <= w_rd_req_d;
      r_miso      <= w_miso_d;
    end
  end

  assign miso     = r_miso;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign rd_req   = r_rd_req;
  assign rd_addr  = r_rd_addr;
  assign busy     = (r_state != IDLE);

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       w_abort;
  logic       r_frame_err;
  logic [7:0] r_err_cnt;

  assign w_abort = w_ss_rise &&
                   ((r_state == ADDR) || (r_state == DATA && !(w_sclk_rise && w_last_bit)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_frame_err <= w_abort;
      if (w_abort && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign frame_err = r_frame_err;
  assign err_cnt   = r_err_cnt;
`endif

endmodule
